// File: rtl/armleocpu_writeback.sv
// armleocpu_writeback: final pipeline stage. Owns the 32x32 integer register
// file, accepts the memory stage's rd write, serves two registered read ports
// and keeps the retired-instruction counter (instret) for the CSR unit.
// Latency: reads return one cycle after the read enable; writes land at the edge.
// Backpressure: none; busy is high during the post-reset clear sweep and
// upstream must stall. Writes and retires seen while busy are dropped.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   m2wb_rd_write/_waddr/_wdata     register write request from memory stage
//   m2wb_retire                     one instruction retires this cycle
//   rs1_read/_addr -> rs1_rdata     read port 1 (registered)
//   rs2_read/_addr -> rs2_rdata     read port 2 (registered)
//   busy                            clear sweep in progress
//   instret                         retired-instruction count (wraps)
//
// Optional feature macro: ARMLEOCPU_WB_BYPASS_EN
//   defined   -> same-cycle write/read of one nonzero register is write-first
//   undefined -> read-first; the execute stage forwards instead
module armleocpu_writeback #(
  parameter int INSTRET_WIDTH  = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m2wb_rd_write,
  input  logic [4:0]               m2wb_rd_waddr,
  input  logic [31:0]              m2wb_rd_wdata,
  input  logic                     m2wb_retire,
  input  logic                     rs1_read,
  input  logic [4:0]               rs1_addr,
  output logic [31:0]              rs1_rdata,
  input  logic                     rs2_read,
  input  logic [4:0]               rs2_addr,
  output logic [31:0]              rs2_rdata,
  output logic                     busy,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [INSTRET_WIDTH-1:0] INSTRET_ONE = {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [4:0]               clear_idx_q, clear_idx_d;
  logic                     busy_q, busy_d;
  logic [31:0]              rs1_rdata_q, rs1_rdata_d;
  logic [31:0]              rs2_rdata_q, rs2_rdata_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

  // x0 is not stored; the array only covers x1..x31.
  logic [31:0] regs_q [1:31];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wr_accept;

  assign wr_accept = (state_q == ST_RUN) && m2wb_rd_write && (m2wb_rd_waddr != 5'd0);

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    busy_d      = busy_q;
    rs1_rdata_d = rs1_rdata_q;
    rs2_rdata_d = rs2_rdata_q;
    instret_d   = instret_q;
    rf_we       = 1'b0;
    rf_waddr    = m2wb_rd_waddr;
    rf_wdata    = m2wb_rd_wdata;

    case (state_q)
      ST_CLEAR: begin
        // The sweep owns the write port; upstream writes are dropped.
        rf_we    = 1'b1;
        rf_waddr = clear_idx_q;
        rf_wdata = 32'd0;
        if (clear_idx_q == 5'd31) begin
          // Hold the index at 31 rather than wrapping onto x0.
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end else begin
          clear_idx_d = clear_idx_q + 5'd1;
        end
      end
      default: begin
        rf_we = wr_accept;
        if (m2wb_retire) begin
          instret_d = instret_q + INSTRET_ONE;
        end
      end
    endcase

    // Read port 1. During the sweep every register reads as zero.
    if (rs1_read) begin
      if ((state_q == ST_CLEAR) || (rs1_addr == 5'd0)) begin
        rs1_rdata_d = 32'd0;
`ifdef ARMLEOCPU_WB_BYPASS_EN
      end else if (wr_accept && (m2wb_rd_waddr == rs1_addr)) begin
        rs1_rdata_d = m2wb_rd_wdata;
`endif
      end else begin
        rs1_rdata_d = regs_q[rs1_addr];
      end
    end

    // Read port 2, identical to port 1.
    if (rs2_read) begin
      if ((state_q == ST_CLEAR) || (rs2_addr == 5'd0)) begin
        rs2_rdata_d = 32'd0;
`ifdef ARMLEOCPU_WB_BYPASS_EN
      end else if (wr_accept && (m2wb_rd_waddr == rs2_addr)) begin
        rs2_rdata_d = m2wb_rd_wdata;
`endif
      end else begin
        rs2_rdata_d = regs_q[rs2_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clear_idx_q <= 5'd1;
      busy_q      <= CLEAR_ON_RESET;
      rs1_rdata_q <= 32'd0;
      rs2_rdata_q <= 32'd0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      busy_q      <= busy_d;
      rs1_rdata_q <= rs1_rdata_d;
      rs2_rdata_q <= rs2_rdata_d;
      instret_q   <= instret_d;
    end
  end

  // Storage array has no reset; the sweep (when enabled) zeroes it.
  // rf_waddr is never 0 when rf_we is set.
  always_ff @(posedge clk) begin
    if (rst_n && rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign rs1_rdata = rs1_rdata_q;
  assign rs2_rdata = rs2_rdata_q;
  assign busy      = busy_q;
  assign instret   = instret_q;

endmodule
